// File: rtl/cti_ctrl_pkg.sv
// Shared types for the CTI counter update controller and its request FIFO.
// The idx field width here must match the INDEX parameter of the controller.
package cti_ctrl_pkg;

    localparam int CTI_INDEX_W = 4;

    typedef enum logic [1:0] {
        CTI_INC = 2'b00,
        CTI_DEC = 2'b01,
        CTI_CLR = 2'b10,
        CTI_NOP = 2'b11
    } cti_op_t;

    typedef struct packed {
        logic [CTI_INDEX_W-1:0] idx;
        cti_op_t                op;
    } cti_upd_t;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } ctrl_state_t;

endpackage

// File: rtl/cti_upd_fifo.sv
// Circular request FIFO accepting up to LANES entries per cycle and releasing one.
// The caller guarantees room for a full set of lanes before asserting any enq_valid.
module cti_upd_fifo
    import cti_ctrl_pkg::*;
#(
    parameter int  LANES  = 4,
    parameter int  QDEPTH = 8,
    localparam int PW     = $clog2(QDEPTH),
    localparam int CW     = $clog2(QDEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clear,
    input  logic [LANES-1:0]     enq_valid,
    input  cti_upd_t [LANES-1:0] enq_data,
    input  logic                 deq,
    output cti_upd_t             head,
    output logic [CW-1:0]        count
);

    cti_upd_t      mem [QDEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] slot [LANES];
    logic [CW-1:0] accepted;

    // Valid lanes are packed into consecutive slots in ascending lane order.
    always_comb begin
        accepted = '0;
        for (int k = 0; k < LANES; k++) begin
            slot[k] = wr_ptr + accepted[PW-1:0];
            if (enq_valid[k]) begin
                accepted = accepted + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int k = 0; k < LANES; k++) begin
            if (enq_valid[k]) begin
                mem[slot[k]] <= enq_data[k];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + accepted[PW-1:0];
            if (deq) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + accepted - CW'(deq);
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/cti_counter_update_ctrl.sv
// Owns the CTI counter RAM read port and write port 0: queues lane updates, drains
// one saturating read-modify-write per cycle and sequences full-table flushes.
module cti_counter_update_ctrl
    import cti_ctrl_pkg::*;
#(
    parameter int  LANES     = 4,
    parameter int  DEPTH     = 16,
    parameter int  INDEX     = 4,
    parameter int  WIDTH     = 8,
    parameter int  QDEPTH    = 8,
    parameter int  STALL_MAX = 3,
    localparam int CW        = $clog2(QDEPTH + 1)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   lookup_valid_i,
    input  logic [INDEX-1:0]       lookup_addr_i,
    output logic                   lookup_grant_o,
    output logic [WIDTH-1:0]       lookup_data_o,
    input  logic [LANES-1:0]       upd_valid_i,
    input  logic [LANES*INDEX-1:0] upd_addr_i,
    input  logic [LANES*2-1:0]     upd_op_i,
    output logic                   upd_ready_o,
    input  logic                   flush_i,
    output logic                   flush_busy_o,
    output logic [CW-1:0]          pending_o,
    output logic [INDEX-1:0]       ram_rd_addr_o,
    input  logic [WIDTH-1:0]       ram_rd_data_i,
    output logic [INDEX-1:0]       ram_wr_addr_o,
    output logic [WIDTH-1:0]       ram_wr_data_o,
    output logic                   ram_we_o
);

    localparam int SW = $clog2(STALL_MAX + 1);

    ctrl_state_t          state;
    ctrl_state_t          state_n;
    logic [INDEX-1:0]     walk;
    logic [INDEX-1:0]     walk_n;
    logic [SW-1:0]        stall_cnt;
    logic [SW-1:0]        stall_n;
    logic [LANES-1:0]     enq_valid;
    cti_upd_t [LANES-1:0] enq_data;
    cti_upd_t             head;
    logic                 fifo_empty;
    logic                 update_wins;
    logic [WIDTH-1:0]     rmw_value;

    assign fifo_empty   = (pending_o == '0);
    assign flush_busy_o = (state == FLUSH);
    assign upd_ready_o  = (state == RUN) && (pending_o <= CW'(QDEPTH - LANES)) && !flush_i;

    // A pending update is forced through once the lookup has won STALL_MAX times in a row.
    assign update_wins    = (state == RUN) && !flush_i && !fifo_empty &&
                            (!lookup_valid_i || (stall_cnt == SW'(STALL_MAX)));
    assign lookup_grant_o = lookup_valid_i && !update_wins;
    assign lookup_data_o  = lookup_grant_o ? ram_rd_data_i : '0;

    always_comb begin
        for (int k = 0; k < LANES; k++) begin
            enq_data[k].idx = upd_addr_i[k*INDEX +: INDEX];
            enq_data[k].op  = cti_op_t'(upd_op_i[k*2 +: 2]);
            enq_valid[k]    = upd_ready_o && upd_valid_i[k] &&
                              (upd_op_i[k*2 +: 2] != CTI_NOP);
        end
    end

    cti_upd_fifo #(
        .LANES  (LANES),
        .QDEPTH (QDEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .clear     (flush_i),
        .enq_valid (enq_valid),
        .enq_data  (enq_data),
        .deq       (update_wins),
        .head      (head),
        .count     (pending_o)
    );

    always_comb begin
        rmw_value = '0;
        case (head.op)
            CTI_INC: rmw_value = (ram_rd_data_i == '1) ? ram_rd_data_i : ram_rd_data_i + 1'b1;
            CTI_DEC: rmw_value = (ram_rd_data_i == '0) ? '0 : ram_rd_data_i - 1'b1;
            default: rmw_value = '0;
        endcase
    end

    always_comb begin
        ram_rd_addr_o = update_wins ? head.idx : lookup_addr_i;
        ram_we_o      = 1'b0;
        ram_wr_addr_o = '0;
        ram_wr_data_o = '0;
        if (state == FLUSH) begin
            ram_we_o      = 1'b1;
            ram_wr_addr_o = walk;
        end else if (update_wins) begin
            ram_we_o      = 1'b1;
            ram_wr_addr_o = head.idx;
            ram_wr_data_o = rmw_value;
        end
    end

    always_comb begin
        state_n = state;
        walk_n  = walk;
        stall_n = '0;
        case (state)
            RUN: begin
                if (flush_i) begin
                    state_n = FLUSH;
                    walk_n  = '0;
                end else if (!fifo_empty && lookup_grant_o) begin
                    stall_n = stall_cnt + 1'b1;
                end
            end
            FLUSH: begin
                if (flush_i) begin
                    walk_n = '0;
                end else if (walk == INDEX'(DEPTH - 1)) begin
                    state_n = RUN;
                end else begin
                    walk_n = walk + 1'b1;
                end
            end
            default: state_n = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= RUN;
            walk      <= '0;
            stall_cnt <= '0;
        end else begin
            state     <= state_n;
            walk      <= walk_n;
            stall_cnt <= stall_n;
        end
    end

endmodule

// File: tb/tb_cti_counter_update_ctrl.sv
// Bench for cti_counter_update_ctrl: directed scenarios plus randomized traffic,
// checked against a queue-and-table model of the counter update rules.
module tb_cti_counter_update_ctrl;

    localparam int LANES     = 4;
    localparam int DEPTH     = 16;
    localparam int INDEX     = 4;
    localparam int WIDTH     = 8;
    localparam int QDEPTH    = 8;
    localparam int STALL_MAX = 3;
    localparam int CW        = $clog2(QDEPTH + 1);

    logic                   clk = 1'b0;
    logic                   reset = 1'b0;
    logic                   lookup_valid_i;
    logic [INDEX-1:0]       lookup_addr_i;
    logic                   lookup_grant_o;
    logic [WIDTH-1:0]       lookup_data_o;
    logic [LANES-1:0]       upd_valid_i;
    logic [LANES*INDEX-1:0] upd_addr_i;
    logic [LANES*2-1:0]     upd_op_i;
    logic                   upd_ready_o;
    logic                   flush_i;
    logic                   flush_busy_o;
    logic [CW-1:0]          pending_o;
    logic [INDEX-1:0]       ram_rd_addr_o;
    logic [WIDTH-1:0]       ram_rd_data_i;
    logic [INDEX-1:0]       ram_wr_addr_o;
    logic [WIDTH-1:0]       ram_wr_data_o;
    logic                   ram_we_o;

    always #5 clk = ~clk;

    cti_counter_update_ctrl #(
        .LANES(LANES), .DEPTH(DEPTH), .INDEX(INDEX),
        .WIDTH(WIDTH), .QDEPTH(QDEPTH), .STALL_MAX(STALL_MAX)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .lookup_valid_i (lookup_valid_i),
        .lookup_addr_i  (lookup_addr_i),
        .lookup_grant_o (lookup_grant_o),
        .lookup_data_o  (lookup_data_o),
        .upd_valid_i    (upd_valid_i),
        .upd_addr_i     (upd_addr_i),
        .upd_op_i       (upd_op_i),
        .upd_ready_o    (upd_ready_o),
        .flush_i        (flush_i),
        .flush_busy_o   (flush_busy_o),
        .pending_o      (pending_o),
        .ram_rd_addr_o  (ram_rd_addr_o),
        .ram_rd_data_i  (ram_rd_data_i),
        .ram_wr_addr_o  (ram_wr_addr_o),
        .ram_wr_data_o  (ram_wr_data_o),
        .ram_we_o       (ram_we_o)
    );

    // Counter RAM with a combinational read port; the preload path seeds entries.
    bit   [WIDTH-1:0] ram [DEPTH];
    logic             pre_en = 1'b0;
    logic [INDEX-1:0] pre_addr = '0;
    logic [WIDTH-1:0] pre_data = '0;

    assign ram_rd_data_i = ram[ram_rd_addr_o];

    always @(posedge clk) begin
        if (ram_we_o === 1'b1) ram[ram_wr_addr_o] <= ram_wr_data_o;
        if (pre_en) ram[pre_addr] <= pre_data;
    end

    int    m_table [DEPTH];
    int    q_idx [$];
    int    q_op [$];
    bit    m_flushing;
    int    m_walk;
    int    m_stall;
    int    checks = 0;
    int    failures = 0;
    string cur_test;

    bit               exp_ready, exp_upd, exp_grant, exp_we, exp_busy;
    logic [WIDTH-1:0] exp_lookup, exp_data;
    logic [INDEX-1:0] exp_addr;
    logic [CW-1:0]    exp_pend;

    function automatic int sat_model(input int old, input int op);
        if (op == 0) return (old + 1 > 255) ? 255 : old + 1;
        if (op == 1) return (old - 1 < 0) ? 0 : old - 1;
        return 0;
    endfunction

    task automatic m_reset();
        q_idx.delete();
        q_op.delete();
        m_flushing = 1'b0;
        m_walk     = 0;
        m_stall    = 0;
    endtask

    task automatic clear_inputs();
        lookup_valid_i = 1'b0;
        lookup_addr_i  = '0;
        upd_valid_i    = '0;
        upd_addr_i     = '0;
        upd_op_i       = '0;
        flush_i        = 1'b0;
    endtask

    task automatic set_lane(input int k, input bit v, input logic [INDEX-1:0] a, input logic [1:0] op);
        upd_valid_i[k]             = v;
        upd_addr_i[k*INDEX +: INDEX] = a;
        upd_op_i[k*2 +: 2]         = op;
    endtask

    // Expected outputs for the current cycle from the queue/table model.
    task automatic predict();
        int pend;
        #2;
        pend       = q_idx.size();
        exp_busy   = m_flushing;
        exp_pend   = CW'(pend);
        exp_ready  = !m_flushing && (QDEPTH - pend >= LANES) && !flush_i;
        exp_upd    = !m_flushing && !flush_i && pend > 0 && (!lookup_valid_i || m_stall == STALL_MAX);
        exp_grant  = lookup_valid_i && !exp_upd;
        exp_lookup = exp_grant ? WIDTH'(m_table[lookup_addr_i]) : '0;
        exp_we     = 1'b0;
        exp_addr   = '0;
        exp_data   = '0;
        if (m_flushing) begin
            exp_we   = 1'b1;
            exp_addr = INDEX'(m_walk);
        end else if (exp_upd) begin
            exp_we   = 1'b1;
            exp_addr = INDEX'(q_idx[0]);
            exp_data = WIDTH'(sat_model(m_table[q_idx[0]], q_op[0]));
        end
    endtask

    task automatic advance();
        int pend;
        pend = q_idx.size();
        @(posedge clk);
        #1;
        if (exp_we) m_table[exp_addr] = int'(exp_data);
        if (pre_en) m_table[pre_addr] = int'(pre_data);
        if (flush_i) begin
            q_idx.delete();
            q_op.delete();
            m_flushing = 1'b1;
            m_walk     = 0;
            m_stall    = 0;
        end else begin
            if (m_flushing) begin
                if (m_walk == DEPTH - 1) m_flushing = 1'b0;
                else m_walk++;
            end
            if (exp_upd) begin
                void'(q_idx.pop_front());
                void'(q_op.pop_front());
            end
            if (exp_ready) begin
                for (int k = 0; k < LANES; k++) begin
                    if (upd_valid_i[k] && upd_op_i[k*2 +: 2] != 2'b11) begin
                        q_idx.push_back(int'(upd_addr_i[k*INDEX +: INDEX]));
                        q_op.push_back(int'(upd_op_i[k*2 +: 2]));
                    end
                end
            end
            m_stall = (pend > 0 && exp_grant) ? m_stall + 1 : 0;
        end
    endtask

    task automatic preload(input int idx, input int val);
        clear_inputs();
        pre_en   = 1'b1;
        pre_addr = INDEX'(idx);
        pre_data = WIDTH'(val);
        predict();
        advance();
        pre_en = 1'b0;
    endtask

    task automatic test_reset();
        cur_test = "reset";
        clear_inputs();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        m_reset();
        checks++;
        if (pending_o !== '0) begin failures++; $display("[TB] FAIL %s pending: got %0d want 0", cur_test, pending_o); end
        checks++;
        if (flush_busy_o !== 1'b0 || ram_we_o !== 1'b0) begin
            failures++; $display("[TB] FAIL %s busy/we: got %b/%b want 0/0", cur_test, flush_busy_o, ram_we_o);
        end
        reset = 1'b1;
        predict();
        checks++;
        if (upd_ready_o !== exp_ready) begin failures++; $display("[TB] FAIL %s ready: got %b want %b", cur_test, upd_ready_o, exp_ready); end
        advance();
    endtask

    task automatic test_single_inc();
        cur_test = "single_inc";
        clear_inputs();
        set_lane(0, 1'b1, 4'd3, 2'b00);
        predict();
        checks++;
        if (ram_we_o !== exp_we) begin failures++; $display("[TB] FAIL %s req_we: got %b want %b", cur_test, ram_we_o, exp_we); end
        advance();
        clear_inputs();
        predict();
        checks++;
        if (ram_we_o !== 1'b1 || ram_wr_addr_o !== 4'd3 || ram_wr_data_o !== 8'd1) begin
            failures++; $display("[TB] FAIL %s write: got we=%b a=%0d d=%0d want 1/3/1", cur_test, ram_we_o, ram_wr_addr_o, ram_wr_data_o);
        end
        advance();
        predict();
        checks++;
        if (pending_o !== exp_pend || exp_pend !== '0) begin failures++; $display("[TB] FAIL %s pending: got %0d want 0", cur_test, pending_o); end
        advance();
        checks++;
        if (ram[3] !== 8'd1) begin failures++; $display("[TB] FAIL %s ram3: got %0d want 1", cur_test, ram[3]); end
    endtask

    task automatic test_back_to_back();
        cur_test = "back_to_back";
        clear_inputs();
        for (int k = 0; k < LANES; k++) set_lane(k, 1'b1, 4'd5, 2'b00);
        predict();
        advance();
        clear_inputs();
        for (int i = 0; i < 4; i++) begin
            predict();
            checks++;
            if (ram_we_o !== 1'b1 || ram_wr_addr_o !== 4'd5 || ram_wr_data_o !== WIDTH'(i + 1)) begin
                failures++; $display("[TB] FAIL %s write%0d: got we=%b a=%0d d=%0d want 1/5/%0d", cur_test, i, ram_we_o, ram_wr_addr_o, ram_wr_data_o, i + 1);
            end
            advance();
        end
        checks++;
        if (ram[5] !== 8'd4) begin failures++; $display("[TB] FAIL %s ram5: got %0d want 4", cur_test, ram[5]); end
    endtask

    task automatic test_saturation();
        cur_test = "saturation";
        preload(2, 255);
        preload(7, 0);
        clear_inputs();
        set_lane(0, 1'b1, 4'd2, 2'b00);
        set_lane(1, 1'b1, 4'd7, 2'b01);
        predict();
        advance();
        clear_inputs();
        predict();
        checks++;
        if (ram_we_o !== 1'b1 || ram_wr_addr_o !== 4'd2 || ram_wr_data_o !== 8'd255) begin
            failures++; $display("[TB] FAIL %s inc: got we=%b a=%0d d=%0d want 1/2/255", cur_test, ram_we_o, ram_wr_addr_o, ram_wr_data_o);
        end
        advance();
        predict();
        checks++;
        if (ram_we_o !== 1'b1 || ram_wr_addr_o !== 4'd7 || ram_wr_data_o !== 8'd0) begin
            failures++; $display("[TB] FAIL %s dec: got we=%b a=%0d d=%0d want 1/7/0", cur_test, ram_we_o, ram_wr_addr_o, ram_wr_data_o);
        end
        advance();
    endtask

    task automatic test_starvation();
        logic [3:0] gpat;
        cur_test = "starvation";
        gpat = '0;
        clear_inputs();
        lookup_valid_i = 1'b1;
        lookup_addr_i  = 4'($urandom_range(0, DEPTH - 1));
        set_lane(0, 1'b1, 4'd9, 2'b00);
        predict();
        advance();
        upd_valid_i = '0;
        for (int i = 0; i < 4; i++) begin
            lookup_addr_i = 4'($urandom_range(0, DEPTH - 1));
            predict();
            gpat = {gpat[2:0], lookup_grant_o};
            checks++;
            if (lookup_data_o !== exp_lookup) begin failures++; $display("[TB] FAIL %s data%0d: got %0d want %0d", cur_test, i, lookup_data_o, exp_lookup); end
            advance();
        end
        checks++;
        if (gpat !== 4'b1110) begin failures++; $display("[TB] FAIL %s grants: got %b want 1110", cur_test, gpat); end
        clear_inputs();
    endtask

    task automatic test_flush();
        cur_test = "flush";
        clear_inputs();
        for (int k = 0; k < LANES; k++) set_lane(k, 1'b1, 4'($urandom_range(0, DEPTH - 1)), 2'b00);
        predict();
        advance();
        upd_valid_i = 4'b0011;
        predict();
        advance();
        clear_inputs();
        flush_i = 1'b1;
        predict();
        checks++;
        if (upd_ready_o !== 1'b0 || pending_o !== 4'd5) begin
            failures++; $display("[TB] FAIL %s start: got ready=%b pend=%0d want 0/5", cur_test, upd_ready_o, pending_o);
        end
        advance();
        flush_i = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            lookup_valid_i = 1'b1;
            lookup_addr_i  = 4'($urandom_range(0, DEPTH - 1));
            predict();
            checks++;
            if (flush_busy_o !== 1'b1 || upd_ready_o !== 1'b0 || pending_o !== '0) begin
                failures++; $display("[TB] FAIL %s walk%0d: got busy=%b ready=%b pend=%0d want 1/0/0", cur_test, i, flush_busy_o, upd_ready_o, pending_o);
            end
            checks++;
            if (ram_we_o !== 1'b1 || ram_wr_addr_o !== INDEX'(i) || ram_wr_data_o !== '0) begin
                failures++; $display("[TB] FAIL %s wr%0d: got we=%b a=%0d d=%0d want 1/%0d/0", cur_test, i, ram_we_o, ram_wr_addr_o, ram_wr_data_o, i);
            end
            checks++;
            if (lookup_grant_o !== 1'b1 || lookup_data_o !== exp_lookup) begin
                failures++; $display("[TB] FAIL %s lookup%0d: got g=%b d=%0d want 1/%0d", cur_test, i, lookup_grant_o, lookup_data_o, exp_lookup);
            end
            advance();
        end
        clear_inputs();
        predict();
        checks++;
        if (flush_busy_o !== 1'b0 || upd_ready_o !== 1'b1) begin
            failures++; $display("[TB] FAIL %s end: got busy=%b ready=%b want 0/1", cur_test, flush_busy_o, upd_ready_o);
        end
        advance();
    endtask

    task automatic test_reset_mid_flush();
        cur_test = "reset_mid_flush";
        clear_inputs();
        flush_i = 1'b1;
        predict();
        advance();
        flush_i = 1'b0;
        for (int i = 0; i < 20 && m_walk != 6; i++) begin
            predict();
            advance();
        end
        predict();
        checks++;
        if (ram_we_o !== 1'b1 || ram_wr_addr_o !== 4'd6) begin
            failures++; $display("[TB] FAIL %s walk6: got we=%b a=%0d want 1/6", cur_test, ram_we_o, ram_wr_addr_o);
        end
        reset = 1'b0;
        #1;
        m_reset();
        checks++;
        if (flush_busy_o !== 1'b0 || ram_we_o !== 1'b0) begin
            failures++; $display("[TB] FAIL %s async: got busy=%b we=%b want 0/0", cur_test, flush_busy_o, ram_we_o);
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
        predict();
        checks++;
        if (pending_o !== '0 || upd_ready_o !== 1'b1 || flush_busy_o !== 1'b0) begin
            failures++; $display("[TB] FAIL %s after: got pend=%0d ready=%b busy=%b want 0/1/0", cur_test, pending_o, upd_ready_o, flush_busy_o);
        end
        advance();
    endtask

    task automatic test_random();
        int budget;
        cur_test = "random";
        for (int c = 0; c < 400; c++) begin
            clear_inputs();
            lookup_valid_i = 1'($urandom_range(0, 1));
            lookup_addr_i  = 4'($urandom_range(0, DEPTH - 1));
            for (int k = 0; k < LANES; k++)
                set_lane(k, ($urandom_range(0, 9) < 4), 4'($urandom_range(0, DEPTH - 1)), 2'($urandom_range(0, 3)));
            flush_i = ($urandom_range(0, 99) == 0);
            predict();
            checks++;
            if (upd_ready_o !== exp_ready) begin failures++; $display("[TB] FAIL %s ready c%0d: got %b want %b", cur_test, c, upd_ready_o, exp_ready); end
            checks++;
            if (lookup_grant_o !== exp_grant) begin failures++; $display("[TB] FAIL %s grant c%0d: got %b want %b", cur_test, c, lookup_grant_o, exp_grant); end
            checks++;
            if (lookup_data_o !== exp_lookup) begin failures++; $display("[TB] FAIL %s ldata c%0d: got %0d want %0d", cur_test, c, lookup_data_o, exp_lookup); end
            checks++;
            if (pending_o !== exp_pend || flush_busy_o !== exp_busy) begin
                failures++; $display("[TB] FAIL %s pend/busy c%0d: got %0d/%b want %0d/%b", cur_test, c, pending_o, flush_busy_o, exp_pend, exp_busy);
            end
            checks++;
            if (ram_we_o !== exp_we) begin failures++; $display("[TB] FAIL %s we c%0d: got %b want %b", cur_test, c, ram_we_o, exp_we); end
            if (exp_we) begin
                checks++;
                if (ram_wr_addr_o !== exp_addr || ram_wr_data_o !== exp_data) begin
                    failures++; $display("[TB] FAIL %s wr c%0d: got a=%0d d=%0d want a=%0d d=%0d", cur_test, c, ram_wr_addr_o, ram_wr_data_o, exp_addr, exp_data);
                end
            end
            advance();
        end
        clear_inputs();
        budget = 0;
        while ((q_idx.size() > 0 || m_flushing) && budget < 60) begin
            predict();
            advance();
            budget++;
        end
        checks++;
        if (pending_o !== '0 || flush_busy_o !== 1'b0) begin
            failures++; $display("[TB] FAIL %s drain: got pend=%0d busy=%b want 0/0 within %0d cycles", cur_test, pending_o, flush_busy_o, budget);
        end
        for (int i = 0; i < DEPTH; i++) begin
            checks++;
            if (ram[i] !== WIDTH'(m_table[i])) begin failures++; $display("[TB] FAIL %s ram%0d: got %0d want %0d", cur_test, i, ram[i], m_table[i]); end
        end
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) m_table[i] = 0;
        m_reset();
        test_reset();
        test_single_inc();
        test_back_to_back();
        test_saturation();
        test_starvation();
        test_flush();
        test_reset_mid_flush();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
